matmul_result_reader: RTL and testbench

MATMUL_RESULT_READER -- requirements
Module: matmul_result_reader

---
 rtl/matmul_result_reader.sv | 91 +++++++++
 tb/tb_matmul_result_reader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/matmul_result_reader.sv
// matmul_result_reader: drains a registered-read result memory into a valid/ready stream
// through a 2-entry buffer, one beat per cycle when downstream is always ready.
module matmul_result_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int MAT_SIZE   = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] res_r_addr,
   input  logic [DATA_WIDTH-1:0] res_r_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic {IDLE, DRAIN} state_t;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAT_SIZE - 1);
   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [ADDR_WIDTH-1:0] buf_idx [2];
   logic                  rd_ptr, wr_ptr;
   logic [1:0]            count;
   logic                  rd_valid;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  all_issued;
   logic                  pop, issue;
   assign out_valid = count != 2'd0;
   assign out_data  = buf_data[rd_ptr];
   assign out_index = buf_idx[rd_ptr];
   assign out_last  = out_valid & (out_index == LAST);
   assign busy      = state == DRAIN;
   // The read in flight is counted as occupying a slot, so the buffer never overflows.
   always_comb begin
      pop      = out_valid & out_ready;
      issue    = (state == DRAIN) & ~all_issued & (((count + 2'(rd_valid)) < 2'd2) | pop);
      state_nx = state;
      if (state == IDLE)
         state_nx = start ? DRAIN : IDLE;
      else
         state_nx = (pop & out_last) ? IDLE : DRAIN;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_r_addr  <= '0;
         all_issued  <= 1'b0;
         rd_valid    <= 1'b0;
         rd_idx      <= '0;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         buf_idx[0]  <= '0;
         buf_idx[1]  <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
         done        <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            res_r_addr <= '0;
            all_issued <= 1'b0;
         end else if (issue) begin
            if (res_r_addr == LAST)
               all_issued <= 1'b1;
            else
               res_r_addr <= res_r_addr + 1'b1;
         end
         rd_valid <= issue;
         if (issue)
            rd_idx <= res_r_addr;
         if (rd_valid) begin
            buf_data[wr_ptr] <= res_r_data;
            buf_idx[wr_ptr]  <= rd_idx;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(rd_valid) - 2'(pop);
         done  <= pop & out_last;
      end
   end
endmodule

// File: tb/tb_matmul_result_reader.sv
// tb_matmul_result_reader: directed vectors plus stream scoreboard for matmul_result_reader.
module tb_matmul_result_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  res_r_addr;
   logic [31:0] res_r_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [5:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [31:0] mem [64];
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct {
      logic st;
      logic rdy;
      logic e_valid;
      logic e_busy;
      int   e_idx;
      int   e_addr;
   } vec_t;
   vec_t tv [9];

   matmul_result_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .res_r_addr(res_r_addr),
      .res_r_data(res_r_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) res_r_data <= mem[res_r_addr];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // mode 0: ready=1, 1: random ready, 2: start pulse at beat 20, 3: start held high
   task automatic drain(input int mode, input int first, input bit do_start);
      int  exp, cyc, a0, a1;
      bit  fin, stall;
      logic [5:0]  s_idx;
      logic [31:0] s_data;
      exp = first; cyc = 0; fin = 0; stall = 0; a0 = -1; a1 = -1;
      if (do_start) begin
         start = 1'b1;
         @(negedge clk);
      end
      while (!fin && cyc < 3000) begin
         start     = (mode == 3) || (mode == 2 && exp == 20);
         out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("done_early", done, 0);
         if (stall) begin
            chk("stall_idx", out_index, s_idx);
            chk("stall_data", out_data, s_data);
         end
         stall = out_valid & ~out_ready;
         s_idx = out_index; s_data = out_data;
         if (out_valid && out_ready) begin
            chk("beat_idx", out_index, exp);
            chk("beat_data", out_data, exp * 3);
            chk("beat_last", out_last, exp == 63);
            if (a0 < 0) a0 = cyc;
            a1 = cyc;
            if (exp == 63) fin = 1;
            exp++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("drain_finished", fin, 1);
      chk("beat_count", exp - first, 64 - first);
      if (mode == 0) chk("no_gap", a1 - a0, 63 - first);
      chk("done_pulse", done, 1);
      chk("busy_after", busy, 0);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("busy_next", busy, mode == 3);
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = i * 3;
      tv[0] = '{1, 0, 0, 1, 0, 0};
      tv[1] = '{0, 0, 0, 1, 0, 1};
      tv[2] = '{0, 0, 1, 1, 0, 2};
      tv[3] = '{0, 0, 1, 1, 0, 2};
      tv[4] = '{0, 0, 1, 1, 0, 2};
      tv[5] = '{0, 1, 1, 1, 1, 3};
      tv[6] = '{0, 1, 1, 1, 2, 4};
      tv[7] = '{0, 0, 1, 1, 2, 4};
      tv[8] = '{0, 1, 1, 1, 3, 5};
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", res_r_addr, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // first-beat latency and early backpressure
      for (int k = 0; k < 9; k++) begin
         start = tv[k].st;
         out_ready = tv[k].rdy;
         @(negedge clk);
         chk("tv_valid", out_valid, tv[k].e_valid);
         chk("tv_busy", busy, tv[k].e_busy);
         chk("tv_addr", res_r_addr, tv[k].e_addr);
         if (tv[k].e_valid) begin
            chk("tv_idx", out_index, tv[k].e_idx);
            chk("tv_data", out_data, tv[k].e_idx * 3);
         end
      end
      drain(0, 3, 0);
      // ten-cycle stall right after the first beat appears
      out_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
      chk("stall_valid_up", out_valid, 1);
      for (int s = 0; s < 10; s++) @(negedge clk);
      chk("stall10_addr", res_r_addr, 2);
      chk("stall10_idx", out_index, 0);
      chk("stall10_data", out_data, 0);
      drain(0, 0, 0);
      drain(1, 0, 1);
      drain(2, 0, 1);
      drain(3, 0, 1);
      drain(0, 0, 0);
      // reset in the middle of a run
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < 200 && !(out_valid && out_index == 6'd30); w++) @(negedge clk);
      chk("reached_beat30", out_index, 30);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_idx", out_index, 0);
      chk("arst_last", out_last, 0);
      chk("arst_addr", res_r_addr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_valid", out_valid, 0);
         chk("post_rst_busy", busy, 0);
      end
      drain(0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
